// File: rtl/ntt_io_streamer_if.sv
// Signal bundle for ntt_io_streamer: command pulses, the input and output
// coefficient streams, the OpenNTT io_ram_* port and status/debug outputs.
// Handshake rule (both streams): a beat transfers on a rising clock edge where
// valid && ready are both high; once valid is raised, it and the payload stay
// stable until that transfer happens; ready may change freely.
interface ntt_io_streamer_if #(
    parameter int LOGQ          = 32,
    parameter int LOGN          = 12,
    parameter int NUM_POLY_MEMS = 2,
    parameter int FIFO_DEPTH    = 8
);
    localparam int SLOT_W = $clog2(NUM_POLY_MEMS);
    localparam int ADDR_W = SLOT_W + LOGN;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    // Command / control
    logic              core_busy;
    logic              load_start;
    logic              unload_start;
    logic [SLOT_W-1:0] poly_sel;

    // Input coefficient stream
    logic              s_valid;
    logic              s_ready;
    logic [LOGQ-1:0]   s_data;
    logic              s_last;

    // Output coefficient stream
    logic              m_valid;
    logic              m_ready;
    logic [LOGQ-1:0]   m_data;
    logic              m_last;

    // OpenNTT I/O RAM port
    logic              io_ram_wen;
    logic [ADDR_W-1:0] io_ram_waddr;
    logic [ADDR_W-1:0] io_ram_raddr;
    logic [LOGQ-1:0]   io_ram_wdata;
    logic [LOGQ-1:0]   io_ram_rdata;

    // Status
    logic              busy;
    logic              load_done;
    logic              unload_done;
    logic              len_err;

    // Debug visibility of the FSM and buffer occupancy
    logic [1:0]        dbg_state;
    logic [CNT_W-1:0]  dbg_fifo_count;
    logic [CNT_W-1:0]  dbg_inflight;

    // Streamer side
    modport slave (
        input  core_busy, load_start, unload_start, poly_sel,
        input  s_valid, s_data, s_last,
        output s_ready,
        output m_valid, m_data, m_last,
        input  m_ready,
        output io_ram_wen, io_ram_waddr, io_ram_raddr, io_ram_wdata,
        input  io_ram_rdata,
        output busy, load_done, unload_done, len_err,
        output dbg_state, dbg_fifo_count, dbg_inflight
    );

    // System / NTT side
    modport master (
        output core_busy, load_start, unload_start, poly_sel,
        output s_valid, s_data, s_last,
        input  s_ready,
        input  m_valid, m_data, m_last,
        output m_ready,
        input  io_ram_wen, io_ram_waddr, io_ram_raddr, io_ram_wdata,
        output io_ram_rdata,
        input  busy, load_done, unload_done, len_err,
        input  dbg_state, dbg_fifo_count, dbg_inflight
    );
endinterface

// File: rtl/ntt_io_streamer.sv
// ntt_io_streamer: moves one polynomial (N = 2**LOGN coefficients) between a
// valid/ready stream and an OpenNTT polynomial slot through the io_ram_* port.
// LOAD writes streamed coefficients into {slot, index}; UNLOAD reads them back
// and buffers the fixed-latency returns in a credit-managed FIFO so the output
// stream may stall at any time.
// Optional build macro NTT_IO_BITREV_EN: the index part of both RAM addresses
// becomes the LOGN-bit bit-reversal of the stream index (memory holds
// bit-reversed order, streams stay in natural order).
// Read timing: a read issued in cycle t registers io_ram_raddr at the end of
// t, and io_ram_rdata for it is valid in cycle t+IO_RD_LAT.
// Parameters must match those of the connected ntt_io_streamer_if.
module ntt_io_streamer #(
    parameter int LOGQ          = 32,
    parameter int LOGN          = 12,
    parameter int NUM_POLY_MEMS = 2,
    parameter int IO_RD_LAT     = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input logic             clk,
    input logic             rst,
    ntt_io_streamer_if.slave io
);
    localparam int SLOT_W = $clog2(NUM_POLY_MEMS);
    localparam int ADDR_W = SLOT_W + LOGN;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W  = LOGQ + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UNLOAD = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Memory-side index for a stream index.
    function automatic logic [LOGN-1:0] mem_index(input logic [LOGN-1:0] idx);
        logic [LOGN-1:0] r;
`ifdef NTT_IO_BITREV_EN
        for (int i = 0; i < LOGN; i++) begin
            r[i] = idx[LOGN-1-i];
        end
`else
        r = idx;
`endif
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [LOGN-1:0]    idx_q, idx_d;
    logic               wen_q, wen_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [LOGQ-1:0]    wdata_q, wdata_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [IO_RD_LAT-1:0] tag_q, tag_d;
    logic [IO_RD_LAT-1:0] tag_last_q, tag_last_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               load_done_q, load_done_d;
    logic               unload_done_q, unload_done_d;
    logic               len_err_q, len_err_d;

    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];

    logic               start_ok;
    logic               accept_load;
    logic               accept_unload;
    logic               idx_last;
    logic               beat;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W:0]     credit_sum;
    logic               issue;
    logic               push;
    logic               pop;
    logic               fifo_nonempty;
    logic [ENT_W-1:0]   head;

    assign start_ok      = (state_q == ST_IDLE) && !io.core_busy;
    assign accept_load   = start_ok && io.load_start;
    assign accept_unload = start_ok && !io.load_start && io.unload_start;
    assign idx_last      = &idx_q;
    assign beat          = (state_q == ST_LOAD) && io.s_valid;
    assign fifo_nonempty = (count_q != '0);
    assign head          = fifo_mem[rd_ptr_q];
    assign push          = tag_q[IO_RD_LAT-1];
    assign pop           = fifo_nonempty && io.m_ready;

    // Count reads whose data has not yet reached the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < IO_RD_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_q[i]);
        end
    end

    // A read may only be issued if a FIFO slot is reserved for its return.
    assign credit_sum = {1'b0, inflight} + {1'b0, count_q};
    assign issue      = (state_q == ST_UNLOAD) && (credit_sum < (CNT_W+1)'(FIFO_DEPTH));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: leave LOAD/UNLOAD on the N-1 beat/read, leave DRAIN on the last pop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_load) begin
                    state_d = ST_LOAD;
                end else if (accept_unload) begin
                    state_d = ST_UNLOAD;
                end
            end
            ST_LOAD: begin
                if (beat && idx_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_UNLOAD: begin
                if (issue && idx_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head[0]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values: writes, reads, tags, FIFO pointers, flags.
    always_comb begin
        slot_d        = slot_q;
        idx_d         = idx_q;
        wen_d         = 1'b0;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        raddr_d       = raddr_q;
        load_done_d   = 1'b0;
        unload_done_d = 1'b0;
        len_err_d     = len_err_q;

        tag_d         = tag_q << 1;
        tag_d[0]      = issue;
        tag_last_d    = tag_last_q << 1;
        tag_last_d[0] = issue && idx_last;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        if (accept_load) begin
            slot_d    = io.poly_sel;
            idx_d     = '0;
            len_err_d = 1'b0;
        end else if (accept_unload) begin
            slot_d = io.poly_sel;
            idx_d  = '0;
        end

        if (beat) begin
            wen_d       = 1'b1;
            waddr_d     = {slot_q, mem_index(idx_q)};
            wdata_d     = io.s_data;
            idx_d       = idx_q + LOGN'(1);
            load_done_d = idx_last;
            if (io.s_last != idx_last) begin
                len_err_d = 1'b1;
            end
        end

        if (issue) begin
            raddr_d = {slot_q, mem_index(idx_q)};
            idx_d   = idx_q + LOGN'(1);
        end

        if ((state_q == ST_DRAIN) && pop && head[0]) begin
            unload_done_d = 1'b1;
        end
    end

    // Datapath registers; reset drops in-flight tags so late RAM returns are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q        <= '0;
            idx_q         <= '0;
            wen_q         <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            raddr_q       <= '0;
            tag_q         <= '0;
            tag_last_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            load_done_q   <= 1'b0;
            unload_done_q <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            wen_q         <= wen_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            raddr_q       <= raddr_d;
            tag_q         <= tag_d;
            tag_last_q    <= tag_last_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            load_done_q   <= load_done_d;
            unload_done_q <= unload_done_d;
            len_err_q     <= len_err_d;
        end
    end

    // FIFO storage: each tagged return is stored as {data, last}.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {io.io_ram_rdata, tag_last_q[IO_RD_LAT-1]};
        end
    end

    assign io.s_ready        = (state_q == ST_LOAD);
    assign io.m_valid        = fifo_nonempty;
    assign io.m_data         = fifo_nonempty ? head[ENT_W-1:1] : '0;
    assign io.m_last         = fifo_nonempty && head[0];
    assign io.io_ram_wen     = wen_q;
    assign io.io_ram_waddr   = waddr_q;
    assign io.io_ram_wdata   = wdata_q;
    assign io.io_ram_raddr   = raddr_q;
    assign io.busy           = (state_q != ST_IDLE);
    assign io.load_done      = load_done_q;
    assign io.unload_done    = unload_done_q;
    assign io.len_err        = len_err_q;
    assign io.dbg_state      = state_q;
    assign io.dbg_fifo_count = count_q;
    assign io.dbg_inflight   = inflight;
endmodule

// File: doc/ntt_io_streamer.md
Name: ntt_io_streamer

Overview:
- Stream adapter between the system-side data path and the OpenNTT word-wide I/O port (io_ram_*).
- LOAD: accepts a valid/ready coefficient stream and writes exactly N coefficients into a selected polynomial slot.
- UNLOAD: reads N coefficients back from a slot and emits them on a backpressured valid/ready stream.
- Credit-based buffering absorbs the fixed I/O read latency, so the output stream can stall at any time without losing data.

Parameters:
- LOGQ, 32, coefficient width in bits.
- LOGN, 12, log2 of the coefficient count N per polynomial.
- NUM_POLY_MEMS, 2, number of polynomial slots; legal values are 2 and 4.
- IO_RD_LAT, 4, cycles from io_ram_raddr to valid io_ram_rdata (RAM_RD_LAT+2); must be ≥1.
- FIFO_DEPTH, 8, output buffer entries; power of two, must be ≥ IO_RD_LAT+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- core_busy  in  1  NTT core is running; new commands are blocked while high.
- load_start  in  1  one-cycle pulse that starts a LOAD.
- unload_start  in  1  one-cycle pulse that starts an UNLOAD.
- poly_sel  in  $clog2(NUM_POLY_MEMS)  slot index, sampled on a start pulse.
- s_valid / s_ready  in / out  1  input stream handshake.
- s_data  in  LOGQ  input coefficient.
- s_last  in  1  marks the final input beat.
- m_valid / m_ready  out / in  1  output stream handshake.
- m_data  out  LOGQ  output coefficient.
- m_last  out  1  high on output beat N-1.
- io_ram_wen  out  1  drives the OpenNTT io_ram_wen.
- io_ram_waddr, io_ram_raddr  out  $clog2(NUM_POLY_MEMS)+LOGN  I/O addresses, formed as {slot, index}.
- io_ram_wdata  out  LOGQ  write data.
- io_ram_rdata  in  LOGQ  read data.
- busy  out  1  high whenever the state is not IDLE.
- load_done, unload_done  out  1  one-cycle completion pulses.
- len_err  out  1  sticky s_last mismatch flag.

Behaviour:
- Reset is asynchronous and active-high. While in reset every output is 0, state is IDLE, counters are 0, the FIFO is empty and in-flight read tags are cleared. Reset mid-operation aborts the transfer; data returning later from the RAM is discarded.
- States: IDLE, LOAD, UNLOAD, DRAIN.
- IDLE:
  - A start pulse is accepted only when core_busy=0.
  - load_start has priority when both start pulses arrive in the same cycle; the unload_start is dropped.
  - Start pulses outside IDLE are ignored.
  - poly_sel is latched on acceptance, and the element counter idx is cleared.
- LOAD:
  - s_ready=1 in this state only.
  - A beat accepted in cycle t produces io_ram_wen=1, io_ram_waddr={slot,idx}, io_ram_wdata=s_data in cycle t+1; all three outputs are registered. idx then increments.
  - When idx reaches N-1 and that beat is accepted, load_done pulses in the same cycle as the final wen, and the next state is IDLE.
  - s_last=1 on a beat other than N-1, or s_last=0 on beat N-1, sets len_err. The load still completes after exactly N beats.
  - io_ram_wen stays 0 outside the write cycles.
- UNLOAD:
  - One read is issued per cycle while (inflight+fifo_count) < FIFO_DEPTH.
  - io_ram_raddr={slot,idx} is registered. A tag shift register of length IO_RD_LAT marks valid returns; each tagged return is pushed into the FIFO as {data, idx==N-1}.
  - After the read for index N-1 is issued, the state moves to DRAIN.
- DRAIN: no further reads are issued. The state stays here until the FIFO is empty and inflight=0 after the last beat has popped.
- Output stream:
  - m_valid = FIFO non-empty, and m_data/m_last come from the FIFO head. A pop happens on m_valid&&m_ready.
  - m_valid must not drop without a handshake.
  - unload_done pulses in the cycle after the m_last handshake, together with the return to IDLE.
- The credit rule guarantees the FIFO never overflows, and a simultaneous push and pop leaves the count unchanged.
- len_err is cleared only by reset or by the next accepted load_start.
- Throughput: 1 beat/cycle in both directions under no backpressure. UNLOAD first-beat latency is IO_RD_LAT+2 cycles after unload_start.

Optional Feature:
- Macro NTT_IO_BITREV_EN.
- When defined, the index part of io_ram_waddr and io_ram_raddr is the LOGN-bit bit-reversal of idx, for both LOAD and UNLOAD. Host streams stay in natural order while memory holds bit-reversed order, as required by the nr/rn NTT types.
- When not defined, addresses use idx directly.
- Stream ordering and m_last are identical in both builds.

Test Plan:
- LOAD, LOGN=3, poly_sel=1, s_data=10..17 back-to-back, s_last on beat 7:
  - waddr = 8..15, each write one cycle after its beat;
  - load_done pulses with the write at waddr 15;
  - len_err=0.
- UNLOAD slot 1 after the LOAD above with m_ready=1: m_data=10..17 on consecutive cycles, first beat 6 cycles after the start, m_last on 17, unload_done the next cycle.
- UNLOAD with m_ready toggling 1 cycle on / 3 cycles off: all 8 values are delivered in order with no loss or duplication; fifo_count never exceeds 8 and inflight+count never exceeds 8.
- s_last on beat 3 of 8 during a LOAD: len_err=1, all 8 writes are still performed, load_done fires; a subsequent load_start clears len_err.
- load_start and unload_start in the same cycle with core_busy=0 gives LOAD only. load_start with core_busy=1 is ignored and busy stays 0.
- rst asserted during an UNLOAD with 3 reads in flight: outputs are 0 immediately; after release, a new UNLOAD returns correct data with no stale beats. In a build with NTT_IO_BITREV_EN, LOAD index 1 goes to address 4 when LOGN=3.
